fetch_icache_ctrl: RTL
======================

// Module: fetch_icache_ctrl
// PURPOSE
//  Read-only, direct-mapped instruction cache and fill controller in front of the fetch stage.
//  Hits return the instruction word in the request cycle. Misses hold stall high and fetch the
//  full line from backing memory as word reads, in order. stall feeds the pipeline's
//  instruction-memory stall.
// PARAMETERS
//  NUM_LINES   32  cache lines; power of 2, >=2
//  LINE_WORDS   4  16-bit words per line; power of 2, >=2
//  MAX_OUTST    4  max outstanding memory reads; must be <= LINE_WORDS
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  rd         in   1   fetch request this cycle
//  addr       in   16  byte address; must be even
//  flush      in   1   fetch redirected; drop the pending miss response
//  inv        in   1   invalidate all lines
//  instr      out  16  instruction word; valid while done=1
//  done       out  1   response valid this cycle
//  stall      out  1   controller busy; fetch must hold its PC
//  hit        out  1   done came from a hit (no fill)
//  err        out  1   misaligned request, or memory error during a fill
//  mem_req    out  1   word read request to backing memory
//  mem_addr   out  16  word-aligned read address
//  mem_gnt    in   1   request accepted this cycle
//  mem_rvalid in   1   read data valid (returns in request order)
//  mem_rdata  in   16  read data
//  mem_err    in   1   qualifies mem_rvalid: returned word is bad
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all valid bits 0, pending-inv 0.
//   All outputs 0: instr, done, stall, hit, err, mem_req, mem_addr.
//  Address split: off=addr[log2(LINE_WORDS):1], index next log2(NUM_LINES) bits, tag = rest.
//  IDLE:
//   rd & addr[0]     -> err=1 for one cycle; done=0; no state change.
//   rd & hit         -> done=1, hit=1, instr=array[index][off], stall=0; stay IDLE.
//   rd & miss        -> stall=1 in the same cycle; latch addr; go to FILL.
//   rd & mem_err     -> not applicable in IDLE; mem_err is only sampled during FILL.
//   no rd            -> all outputs 0.
//   flush            -> ignored in IDLE.
//  FILL:
//   Issue word reads 0..LINE_WORDS-1 of the line in order; mem_req/mem_addr hold until mem_gnt.
//   Outstanding reads (issued, not yet returned) never exceed MAX_OUTST.
//   Each mem_rvalid writes the next word into the data array and increments a return counter.
//   On the last return: write the tag; set valid unless any return had mem_err; go to RESPOND.
//   stall=1 throughout.
//  RESPOND (1 cycle):
//   done=1, hit=0, instr=filled word at the latched offset, stall=0; go to IDLE.
//   A new rd in this cycle is not accepted; fetch re-presents it next cycle.
//   If any return had mem_err: err=1, done=0; the line stays invalid.
//  flush during FILL or RESPOND: set drop flag; the fill always completes (reads cannot be
//   cancelled) and the line is installed; RESPOND then drives done=0; drop cleared on IDLE.
//  inv: in IDLE, clears all valid bits at the next edge; an rd in that cycle is looked up
//   before the clear. Outside IDLE, inv sets pending-inv, applied on entry to IDLE, after the
//   current line's install.
//  Miss latency: with mem_gnt=1 and 2-cycle memory latency, done is 7 cycles after the miss.
//  Reset mid-fill: everything returns to reset values; late mem_rvalid in IDLE is ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined: 16-bit saturating outputs hit_cnt and miss_cnt, cleared by reset.
//   Each counts done cycles, split by the hit output.
//  ICACHE_STATS_EN undefined: no counters and no ports.
// STRUCTURE
//  Shared package cache_pkg: FSM state enum (IDLE, FILL, RESPOND), and tag/index/offset width
//   functions derived from the parameters.
//  One sub-module, icache_data_array: tag, valid and data storage.
//   Combinational read port; synchronous write port; single-cycle valid clear.
// TESTING
//  1. Cold miss at 0x0010, memory returns 0x1111..0x4444 (2-cycle latency)
//     -> stall 7 cycles, done with instr=0x1111, hit=0.
//  2. Then rd 0x0014 -> same-cycle done, hit=1, instr=0x3333, stall=0.
//  3. rd 0x0011 -> err=1, done=0, mem_req never asserted.
//  4. Miss at 0x0100, flush 2 cycles later -> 4 reads complete, no done;
//     then rd 0x0100 hits.
//  5. inv mid-fill -> RESPOND done=1, then the same address misses again.
//  6. mem_err on word 2 of a fill -> err=1 in RESPOND, retry of the address misses;
//     with ICACHE_STATS_EN, cases 1-2 give hit_cnt=1, miss_cnt=1.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and address-split widths for the fetch icache
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Byte bit 0 is never part of the word address, hence the extra 1.
  function automatic int tag_width(input int num_lines, input int line_words);
    return ADDR_W - 1 - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - tag/valid/data storage: combinational read, synchronous write, bulk valid clear
module icache_data_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 5,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 8
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [OFF_W-1:0]  i_rd_off,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [OFF_W-1:0]  i_wr_off,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_tag_wdata,
  input  logic              i_valid_wdata,
  input  logic              i_clr_all
);

  logic [DATA_W-1:0]    r_data [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    if (i_tag_we) r_tag[i_wr_idx] <= i_tag_wdata;
  end

  // Tag install and bulk clear never coincide: install happens in FILL, clear in IDLE/RESPOND.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_idx] <= i_valid_wdata;
    end
  end

endmodule

// File: rtl/fetch_icache_ctrl.sv
// rtl/fetch_icache_ctrl.sv - direct-mapped read-only icache and line-fill controller
// Optional hit/miss counters: define ICACHE_STATS_EN.
module fetch_icache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        inv,
  output logic [15:0] instr,
  output logic        done,
  output logic        stall,
  output logic        hit,
  output logic        err,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(NUM_LINES);
  localparam int TAG_W = tag_width(NUM_LINES, LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_RET   = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_ISSUED = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] OUTST_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e r_state, w_next_state;

  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic [CNT_W-1:0] r_issue, r_ret, r_outst;
  logic             r_err, r_drop, r_pend_inv;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [OFF_W-1:0]  w_rd_off;
  logic [DATA_W-1:0] w_arr_data;
  logic [TAG_W-1:0]  w_arr_tag;
  logic              w_arr_valid;
  logic              w_lookup_hit;
  logic              w_issue, w_ret, w_last_ret;
  logic              w_clr_all;

  assign w_off = addr[OFF_W:1];
  assign w_idx = addr[OFF_W+IDX_W:OFF_W+1];
  assign w_tag = addr[ADDR_W-1:OFF_W+IDX_W+1];

  // The single read port serves the live lookup in IDLE and the latched word in RESPOND.
  assign w_rd_idx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_rd_off = (r_state == IDLE) ? w_off : r_off;

  assign w_lookup_hit = w_arr_valid && (w_arr_tag == w_tag);
  assign w_issue      = mem_req & mem_gnt;
  assign w_ret        = (r_state == FILL) & mem_rvalid;
  assign w_last_ret   = w_ret && (r_ret == LAST_RET);

  icache_data_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W),
    .OFF_W     (OFF_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk          (clk),
    .i_rst_n      (rst),
    .i_rd_idx     (w_rd_idx),
    .i_rd_off     (w_rd_off),
    .o_rd_data    (w_arr_data),
    .o_rd_tag     (w_arr_tag),
    .o_rd_valid   (w_arr_valid),
    .i_wr_en      (w_ret),
    .i_wr_idx     (r_idx),
    .i_wr_off     (r_ret[OFF_W-1:0]),
    .i_wr_data    (mem_rdata),
    .i_tag_we     (w_last_ret),
    .i_tag_wdata  (r_tag),
    .i_valid_wdata(~(r_err | mem_err)),
    .i_clr_all    (w_clr_all)
  );

  always_comb begin
    w_next_state = r_state;
    w_clr_all    = 1'b0;
    instr        = '0;
    done         = 1'b0;
    stall        = 1'b0;
    hit          = 1'b0;
    err          = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    unique case (r_state)
      IDLE: begin
        w_clr_all = inv;
        if (rd) begin
          if (addr[0]) begin
            err = 1'b1;
          end else if (w_lookup_hit) begin
            done  = 1'b1;
            hit   = 1'b1;
            instr = w_arr_data;
          end else begin
            stall        = 1'b1;
            w_next_state = FILL;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        if ((r_issue != ALL_ISSUED) && (r_outst != OUTST_MAX)) begin
          mem_req  = 1'b1;
          mem_addr = {r_tag, r_idx, r_issue[OFF_W-1:0], 1'b0};
        end
        if (w_last_ret) w_next_state = RESPOND;
      end
      RESPOND: begin
        // A flush arriving in this very cycle still suppresses the response.
        if (!(r_drop || flush)) begin
          if (r_err) begin
            err = 1'b1;
          end else begin
            done  = 1'b1;
            instr = w_arr_data;
          end
        end
        w_clr_all    = r_pend_inv | inv;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tag      <= '0;
      r_idx      <= '0;
      r_off      <= '0;
      r_issue    <= '0;
      r_ret      <= '0;
      r_outst    <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
      r_pend_inv <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          if (w_next_state == FILL) begin
            r_tag   <= w_tag;
            r_idx   <= w_idx;
            r_off   <= w_off;
            r_issue <= '0;
            r_ret   <= '0;
            r_outst <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
          end
        end
        FILL: begin
          if (w_issue) r_issue <= r_issue + CNT_ONE;
          if (w_ret) r_ret <= r_ret + CNT_ONE;
          if (w_issue && !w_ret) r_outst <= r_outst + CNT_ONE;
          else if (!w_issue && w_ret) r_outst <= r_outst - CNT_ONE;
          if (w_ret && mem_err) r_err <= 1'b1;
          if (flush) r_drop <= 1'b1;
          if (inv) r_pend_inv <= 1'b1;
        end
        RESPOND: begin
          r_drop     <= 1'b0;
          r_pend_inv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (done) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
